bcd_serial_addsub: RTL and testbench



---
 rtl/bcd_serial_addsub.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// bcd_serial_addsub
//
// Digit-serial multi-digit BCD adder/subtractor sequencer. One BCD digit pair
// is pushed through a digit-sum four_bit_add stage and a +6 correction
// four_bit_add stage per clock. Subtraction is done by 10's complement. A
// negative result is re-complemented in a second serial pass, so the result
// is reported as sign plus magnitude.
//
// Optional build macro: BCD_INPUT_CHECK_EN
//   defined   : err flags any operand nibble >9 seen on an accepted start
//   undefined : err is tied low and no check logic exists
//
// Parameters:
//   DIGITS  number of BCD digits per operand (>=1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   sub    in   0 = a+b, 1 = a-b (latched on accepted start)
//   a, b   in   BCD operands, digit 0 in [3:0] (latched on accepted start)
//   busy   out  high from the cycle after an accepted start until done
//   done   out  single-cycle pulse, result valid
//   s      out  BCD result magnitude, held until the next accepted start
//   c      out  decimal carry out for add, 0 for sub
//   neg    out  result negative for sub, 0 for add
//   err    out  invalid digit seen in a or b for this operation
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// four_bit_add
//
// Plain 4-bit ripple-carry adder.
//
// Ports:
//   a, b  in   4-bit addends
//   ci    in   carry in
//   s     out  4-bit sum
//   co    out  carry out
// ---------------------------------------------------------------------------
module four_bit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  // Ripple the carry through four full-adder cells.
  always_comb begin
    logic carry_v;
    carry_v = ci;
    s       = 4'd0;
    for (int i = 0; i < 4; i++) begin
      s[i]    = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | (a[i] & carry_v) | (b[i] & carry_v);
    end
    co = carry_v;
  end

endmodule

module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                c,
  output logic                neg,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             sub_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     s_r;
  logic             busy_r;
  logic             done_r;
  logic             c_r;
  logic             neg_r;

  logic [3:0]       dig_x_s;
  logic [3:0]       dig_y_s;
  logic [3:0]       raw_lo_s;
  logic             raw_hi_s;
  logic             need_fix_s;
  logic [3:0]       fix_addend_s;
  logic [3:0]       dig_out_s;
  logic             fix_co_s;
  logic             carry_next_s;
  logic             last_s;

  // Operand selection: RUN adds a[i] to b[i] or its 9's complement, COMP
  // re-complements the stored digit (the +1 of the 10's complement arrives as
  // the carry seeded on entry to each pass).
  always_comb begin
    dig_x_s = 4'd0;
    dig_y_s = 4'd0;
    case (state_r)
      RUN: begin
        dig_x_s = a_r[{idx_r, 2'b00} +: 4];
        if (sub_r) begin
          dig_y_s = 4'd9 - b_r[{idx_r, 2'b00} +: 4];
        end else begin
          dig_y_s = b_r[{idx_r, 2'b00} +: 4];
        end
      end
      COMP: begin
        dig_x_s = 4'd9 - s_r[{idx_r, 2'b00} +: 4];
        dig_y_s = 4'd0;
      end
      default: begin
        dig_x_s = 4'd0;
        dig_y_s = 4'd0;
      end
    endcase
  end

  // Binary digit sum; {raw_hi_s, raw_lo_s} is the 5-bit raw digit sum.
  four_bit_add u_digit_sum (
    .a  (dig_x_s),
    .b  (dig_y_s),
    .ci (carry_r),
    .s  (raw_lo_s),
    .co (raw_hi_s)
  );

  // Decide whether the raw sum left the 0..9 range and needs +6.
  always_comb begin
    need_fix_s = raw_hi_s | (raw_lo_s > 4'd9);
    if (need_fix_s) begin
      fix_addend_s = 4'd6;
    end else begin
      fix_addend_s = 4'd0;
    end
  end

  // Decimal correction stage.
  four_bit_add u_digit_fix (
    .a  (raw_lo_s),
    .b  (fix_addend_s),
    .ci (1'b0),
    .s  (dig_out_s),
    .co (fix_co_s)
  );

  // A raw sum of 10..15 overflows only in the +6 stage, 16 and above already
  // overflowed in the sum stage, so either carry means raw>9.
  always_comb begin
    carry_next_s = raw_hi_s | fix_co_s;
    last_s       = (idx_r == IDX_LAST);
  end

  // Sequencer: operand capture, per-digit stepping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sub_r   <= 1'b0;
      idx_r   <= IDX_ZERO;
      carry_r <= 1'b0;
      s_r     <= {W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      c_r     <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            idx_r   <= IDX_ZERO;
            carry_r <= sub;
            c_r     <= 1'b0;
            neg_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          s_r[{idx_r, 2'b00} +: 4] <= dig_out_s;
          carry_r                  <= carry_next_s;
          if (last_s) begin
            idx_r <= IDX_ZERO;
            if (!sub_r) begin
              c_r     <= carry_next_s;
              state_r <= DONE;
            end else if (carry_next_s) begin
              // No borrow: the 10's complement sum is already the magnitude.
              neg_r   <= 1'b0;
              state_r <= DONE;
            end else begin
              // Borrow: result is negative, re-complement it digit by digit.
              neg_r   <= 1'b1;
              carry_r <= 1'b1;
              state_r <= COMP;
            end
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        COMP: begin
          s_r[{idx_r, 2'b00} +: 4] <= dig_out_s;
          carry_r                  <= carry_next_s;
          if (last_s) begin
            // Carry out of the top digit is dropped.
            idx_r   <= IDX_ZERO;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_r;

  // True when any nibble of the operand is not a BCD digit.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad_v;
    bad_v = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad_v = 1'b1;
      end
    end
    return bad_v;
  endfunction

  // Operand digit check, evaluated once per accepted start and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      err_r <= has_bad_digit(a) | has_bad_digit(b);
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign c    = c_r;
  assign neg  = neg_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4). Stimulus pushes the
// hand-computed expected result into a scoreboard queue; an independent
// monitor pops and compares on every done pulse.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT_1  = DIGITS + 1;
  localparam int LAT_2  = 2 * DIGITS + 1;

`ifdef BCD_INPUT_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c;
  logic         neg;
  logic         err;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         neg;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  exp_t q[$];
  int   total      = 0;
  int   bad        = 0;
  int   done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_count++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("s",            s,          e.s);
        check("c",            c,          e.c);
        check("neg",          neg,        e.neg);
        check("err",          err,        e.err);
        check("busy_at_done", busy,       1'b0);
        check("latency",      cyc - e.t0, e.lat);
      end
    end
  end

  // Issue one operation from a negedge-aligned point and queue its result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic [W-1:0] es, input logic ec, input logic en,
                       input logic ee, input int lat);
    exp_t x;
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x.s = es; x.c = ec; x.neg = en; x.err = ee; x.lat = lat; x.t0 = cyc;
    q.push_back(x);
    check("busy_after_start", busy, 1'b1);
  endtask

  // Wait, bounded, until the monitor has consumed every queued result.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL done_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         neg;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[10];
  int   dc0;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0,   LAT_1};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0,   LAT_1};
    vecs[2] = '{16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b0,   LAT_1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0,   LAT_1};
    vecs[4] = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0,   LAT_1};
    vecs[5] = '{16'h5000, 16'h5000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0,   LAT_1};
    vecs[6] = '{16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0,   LAT_2};
    vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0,   LAT_2};
    vecs[8] = '{16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b0, ERR_ON, LAT_1};
    vecs[9] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0,   LAT_1};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s",    s,    16'h0000);
    check("rst_c",    c,    1'b0);
    check("rst_neg",  neg,  1'b0);
    check("rst_err",  err,  1'b0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c,
            vecs[i].neg, vecs[i].err, vecs[i].lat);
      drain();
    end

    // Reset two digits into RUN, with start also high: rst wins, no done.
    dc0   = done_count;
    a     = 16'h1111;
    b     = 16'h2222;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_s",    s,    16'h0000);
    check("abort_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_count, dc0);
    check("abort_idle",    busy,       1'b0);

    // Normal operation after the abort.
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, LAT_1);
    drain();

    // start re-pulsed while busy must be ignored.
    dc0 = done_count;
    issue(16'h4321, 16'h1234, 1'b1, 16'h3087, 1'b0, 1'b0, 1'b0, LAT_1);
    @(negedge clk);
    a     = 16'h9999;
    b     = 16'h9999;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    check("repulse_one_done", done_count, dc0 + 1);
    check("repulse_idle",     busy,       1'b0);
    check("repulse_s_held",   s,          16'h3087);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
